// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, no parity, one stop bit, LSB first.
// The serial line is synchronised, the start bit is confirmed at its centre,
// and every following bit is sampled one full bit period after the previous one.
module uart_rx #(
    parameter int WCNT = 50  // clock cycles per bit, legal 4..1023
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic       w_rx,
    output logic [7:0] r_data,
    output logic       r_valid,
    output logic       r_ferr,
    output logic       r_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAITHI
    } state_t;

    // Sample points: centre of the start bit, then one full bit later each time.
    localparam logic [9:0] HALF_LAST = 10'(WCNT / 2 - 1);
    localparam logic [9:0] BIT_LAST  = 10'(WCNT - 1);

    // Synchroniser flops; both idle high so reset does not look like a start edge.
    logic sync1_q;
    logic rxs_q;

    state_t     state_q, state_d;
    logic [9:0] cnt_q,   cnt_d;
    logic [2:0] idx_q,   idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       ferr_q,  ferr_d;
    logic       busy_q,  busy_d;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let rxs_q take the old sync1_q, forming two real stages.
            sync1_q <= w_rx;
            rxs_q   <= sync1_q;
        end
    end

    // Next-state and output computation for the receive FSM.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (rxs_q) begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ferr_d  = ~rxs_q;
                    cnt_d   = '0;
                    // A low stop bit may be a break; wait for the line to recover.
                    state_d = rxs_q ? ST_IDLE : ST_WAITHI;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            ST_WAITHI: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            // NOTE: only a handful of flops, so all of them are reset; nothing here is a memory.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign r_data  = data_q;
    assign r_valid = valid_q;
    assign r_ferr  = ferr_q;
    assign r_busy  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames and compares received bytes
// against a queue of expected frames built from what was sent.
module tb_uart_rx;

    localparam int WCNT = 50;

    logic       clk = 1'b0;
    logic       w_rst;
    logic       w_rx;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ferr;
    logic       r_busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         cyc;
    } rx_t;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    rx_t  rx_q[$];
    exp_t exp_q[$];

    uart_rx #(.WCNT(WCNT)) dut (
        .w_clk  (clk),
        .w_rst  (w_rst),
        .w_rx   (w_rx),
        .r_data (r_data),
        .r_valid(r_valid),
        .r_ferr (r_ferr),
        .r_busy (r_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Record every valid pulse seen away from the active edge.
    always @(negedge clk) begin
        if (r_valid === 1'b1) rx_q.push_back('{r_data, r_ferr, cycle});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one frame starting at the current negedge; a low stop bit can be
    // stretched by tail_low extra cycles to form a break.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit,
                              input int tail_low, output int start_cyc);
        w_rx      = 1'b0;
        start_cyc = cycle;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            w_rx = b[i];
            repeat (cpb) @(negedge clk);
        end
        w_rx = stop_bit;
        repeat (cpb) @(negedge clk);
        if (!stop_bit) repeat (tail_low) @(negedge clk);
        w_rx = 1'b1;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset;
        w_rst = 1'b1;
        w_rx  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({r_data, r_valid, r_ferr, r_busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b busy=%b required all 0",
                     r_data, r_valid, r_ferr, r_busy);
        end
        w_rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({r_valid, r_busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b busy=%b required 0 0", r_valid, r_busy);
        end
    endtask

    task automatic test_single_frame;
        int s;
        bit ok;
        rx_q.delete();
        send_frame(8'h61, WCNT, 1'b1, 0, s);
        wait_rx(1, 100, ok);
        repeat (100) @(negedge clk);
        checks++;
        if (rx_q.size() !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d pulses required 1", rx_q.size());
        end
        if (rx_q.size() >= 1) begin
            checks++;
            if (rx_q[0].data !== 8'h61 || rx_q[0].ferr !== 1'b0) begin
                errors++;
                $display("FAIL single_data: got %h ferr=%b required 61 ferr=0",
                         rx_q[0].data, rx_q[0].ferr);
            end
            checks++;
            if (rx_q[0].cyc - s < 477 || rx_q[0].cyc - s > 479) begin
                errors++;
                $display("FAIL single_latency: got %0d cycles required 478+/-1", rx_q[0].cyc - s);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   s;
        bit   ok;
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'hA5};
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{bytes[i], 1'b0});
            send_frame(bytes[i], WCNT, 1'b1, 0, s);
        end
        wait_rx(3, 200, ok);
        repeat (200) @(negedge clk);
        checks++;
        if (rx_q.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses required 3", rx_q.size());
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i].data !== exp_q[i].data || rx_q[i].ferr !== exp_q[i].ferr) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h ferr=%b required %h ferr=%b",
                         i, rx_q[i].data, rx_q[i].ferr, exp_q[i].data, exp_q[i].ferr);
            end
        end
        // Output must hold the last byte while idle.
        checks++;
        if (r_data !== 8'hA5 || r_ferr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: got %h ferr=%b required a5 ferr=0", r_data, r_ferr);
        end
    endtask

    task automatic test_glitch;
        int k = 0;
        rx_q.delete();
        w_rx = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (r_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_rise: got busy=%b required 1", r_busy);
        end
        repeat (5) @(negedge clk);
        w_rx = 1'b1;
        while (r_busy !== 1'b0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (r_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_fall: got busy=%b after 30 cycles required 0", r_busy);
        end
        repeat (600) @(negedge clk);
        checks++;
        if (rx_q.size() !== 0) begin
            errors++;
            $display("FAIL glitch_novalid: got %0d pulses required 0", rx_q.size());
        end
    endtask

    task automatic test_break;
        int s;
        bit ok;
        rx_q.delete();
        send_frame(8'h3C, WCNT, 1'b0, 2000, s);
        repeat (20) @(negedge clk);
        send_frame(8'h55, WCNT, 1'b1, 0, s);
        wait_rx(2, 200, ok);
        repeat (100) @(negedge clk);
        checks++;
        if (rx_q.size() !== 2) begin
            errors++;
            $display("FAIL break_count: got %0d pulses required 2", rx_q.size());
        end
        if (rx_q.size() >= 2) begin
            checks++;
            if (rx_q[0].data !== 8'h3C || rx_q[0].ferr !== 1'b1) begin
                errors++;
                $display("FAIL break_frame: got %h ferr=%b required 3c ferr=1",
                         rx_q[0].data, rx_q[0].ferr);
            end
            checks++;
            if (rx_q[1].data !== 8'h55 || rx_q[1].ferr !== 1'b0) begin
                errors++;
                $display("FAIL break_recover: got %h ferr=%b required 55 ferr=0",
                         rx_q[1].data, rx_q[1].ferr);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int   s;
        bit   ok;
        logic [7:0] b = 8'h7E;
        rx_q.delete();
        w_rx = 1'b0;
        repeat (WCNT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            w_rx = b[i];
            repeat (WCNT) @(negedge clk);
        end
        w_rx = b[4];
        repeat (20) @(negedge clk);
        checks++;
        if (r_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got busy=%b required 1", r_busy);
        end
        #2 w_rst = 1'b1;
        #1;
        checks++;
        if ({r_data, r_valid, r_ferr, r_busy} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_async: got data=%h valid=%b ferr=%b busy=%b required all 0",
                     r_data, r_valid, r_ferr, r_busy);
        end
        w_rx = 1'b1;
        repeat (10) @(negedge clk);
        w_rst = 1'b0;
        repeat (600) @(negedge clk);
        checks++;
        if (rx_q.size() !== 0 || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got %0d pulses busy=%b required 0 pulses busy=0",
                     rx_q.size(), r_busy);
        end
        send_frame(8'h7E, WCNT, 1'b1, 0, s);
        wait_rx(1, 100, ok);
        checks++;
        if (!ok || rx_q[0].data !== 8'h7E || rx_q[0].ferr !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next: got %0d pulses data=%h required 1 pulse data=7e ferr=0",
                     rx_q.size(), ok ? rx_q[0].data : 8'h00);
        end
    endtask

    task automatic test_baud_tolerance;
        int s;
        bit ok;
        rx_q.delete();
        send_frame(8'hC3, 48, 1'b1, 0, s);
        send_frame(8'hC3, 52, 1'b1, 0, s);
        wait_rx(2, 200, ok);
        repeat (100) @(negedge clk);
        checks++;
        if (rx_q.size() !== 2) begin
            errors++;
            $display("FAIL baud_count: got %0d pulses required 2", rx_q.size());
        end
        for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i].data !== 8'hC3 || rx_q[i].ferr !== 1'b0) begin
                errors++;
                $display("FAIL baud_%0d: got %h ferr=%b required c3 ferr=0",
                         i == 0 ? 48 : 52, rx_q[i].data, rx_q[i].ferr);
            end
        end
    endtask

    task automatic test_random;
        int   s;
        bit   ok;
        logic [7:0] b;
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back('{b, 1'b0});
            send_frame(b, int'($urandom_range(48, 52)), 1'b1, 0, s);
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        wait_rx(12, 200, ok);
        repeat (100) @(negedge clk);
        checks++;
        if (rx_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d pulses required %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i].data !== exp_q[i].data || rx_q[i].ferr !== exp_q[i].ferr) begin
                errors++;
                $display("FAIL random_frame%0d: got %h ferr=%b required %h ferr=%b",
                         i, rx_q[i].data, rx_q[i].ferr, exp_q[i].data, exp_q[i].ferr);
            end
        end
    endtask

    initial begin
        w_rst = 1'b1;
        w_rx  = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_baud_tolerance();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: m_uart_rx

Interface
REQ-001 SHALL have parameter WCNT, default 50, meaning clock cycles per bit (50 MHz / 50 = 1 Mbaud); legal range 4..1023.
REQ-002 SHALL have port w_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port w_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port w_rx, input, 1 bit: UART serial line, asynchronous to w_clk, idle high.
REQ-005 SHALL have port r_data, output, 8 bits: last received byte.
REQ-006 SHALL have port r_valid, output, 1 bit: one-cycle pulse, new r_data/r_ferr available.
REQ-007 SHALL have port r_ferr, output, 1 bit: framing error for the byte flagged by r_valid.
REQ-008 SHALL have port r_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-009 SHALL pass w_rx through a 2-flop synchronizer, both flops reset to 1; all decisions use the second flop (rxs).
REQ-010 SHALL use states IDLE, START, DATA, STOP, WAITHI, with a 10-bit cycle counter and a 3-bit bit index.
REQ-011 SHALL in IDLE, on rxs==0, go to START with counter=0.
REQ-012 SHALL in START, increment the counter each cycle and sample rxs when counter==WCNT/2-1 (integer divide).
REQ-013 SHALL on a START sample of rxs==1 (glitch) return to IDLE with no r_valid; on rxs==0 go to DATA, counter=0, bit index=0.
REQ-014 SHALL in DATA, sample rxs when counter==WCNT-1, shift it into a shift register LSB first, reset the counter to 0, and increment the bit index.
REQ-015 SHALL go from DATA to STOP, counter=0, after the sample taken at bit index 7.
REQ-016 SHALL in STOP, sample rxs when counter==WCNT-1.
REQ-017 SHALL on a STOP sample of 1: on the next cycle load r_data, set r_ferr=0, pulse r_valid, and go to IDLE.
REQ-018 SHALL on a STOP sample of 0: on the next cycle load r_data, set r_ferr=1, pulse r_valid, and go to WAITHI.
REQ-019 SHALL in WAITHI remain until rxs==1, then go to IDLE; a held-low break line therefore yields exactly one byte.
REQ-020 SHALL assert r_valid for exactly one cycle per completed frame, with no ready/backpressure.
REQ-021 SHALL hold r_data and r_ferr stable between r_valid pulses.
REQ-022 SHALL produce back-to-back frames: a start edge arriving immediately after a stop bit SHALL be accepted with no lost byte.
REQ-023 SHALL give a latency of 2 + WCNT/2 + 9*WCNT + 1 cycles, +/-1, from the falling start edge on w_rx to r_valid.

Reset
REQ-024 SHALL, while w_rst is high (asynchronously), set state=IDLE, counter=0, bit index=0, shift register=0, r_data=0, r_valid=0, r_ferr=0, r_busy=0, and synchronizer flops=1.
REQ-025 SHALL abort a frame in progress when reset occurs mid-frame, emitting no r_valid for it; after release, reception resumes only on a new falling edge.

Verification
REQ-026 SHALL check a single frame, WCNT=50, byte 8'h61 at exactly 50 cycles/bit -> one r_valid pulse 478+/-1 cycles after the start edge, r_data=8'h61, r_ferr=0.
REQ-027 SHALL check loopback of an m_uart_tx instance sending 8'h00, 8'hFF, 8'hA5 back-to-back -> three r_valid pulses carrying 00, FF, A5, all r_ferr=0.
REQ-028 SHALL check a 10-cycle low glitch on idle w_rx -> no r_valid; r_busy returns to 0 within 30 cycles.
REQ-029 SHALL check a frame 8'h3C with stop bit forced 0, followed by 2000 cycles low -> exactly one r_valid with r_data=8'h3C and r_ferr=1; a following good 8'h55 frame is received with r_ferr=0.
REQ-030 SHALL check w_rst pulsed during bit 4 of a frame -> outputs 0 immediately with no clock needed, no r_valid for the aborted frame, and the next full 8'h7E frame is received correctly.
REQ-031 SHALL check baud tolerance: 8'hC3 sent at 48 and at 52 cycles/bit -> received correctly with r_ferr=0.
